pixel_stream_feeder: RTL and testbench
======================================

# pixel_stream_feeder

Upstream feeder for the 36 MHz VGA core. It accepts an RGB444 pixel stream over a valid/ready handshake and buffers it in a FIFO. It releases one pixel per cycle while the core reports `drawing_pixels`, and drives black when the core is blanking. It aligns the stream to frame boundaries using a start-of-frame flag, and recovers from underflow by resynchronising at the next frame.

## Interface
Parameters:
- `DEPTH`, 1024: FIFO depth in pixels; power of two, ≥ 16.
- `START_LEVEL`, 512: minimum FIFO level required before streaming starts; 1 ≤ value ≤ `DEPTH`.
- `FRAME_PIXELS`, 480000: active pixels per frame (800×600).

Ports:
- `clk` in 1: 36 MHz pixel clock. It is the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `s_data` in 12: pixel data; [11:8] R, [7:4] G, [3:0] B.
- `s_sof` in 1: marks `s_data` as the first pixel of a frame.
- `s_valid` in 1: upstream has a pixel.
- `s_ready` out 1: feeder accepts a pixel this cycle.
- `frame_start` in 1: one-cycle pulse from the timing core at the first blanking line before active video.
- `drawing_pixels` in 1: the core consumes one pixel this cycle.
- `r`, `g`, `b` out 4 each: registered pixel out to the core.
- `level` out clog2(DEPTH)+1: FIFO occupancy.
- `underflow` out 1: sticky; cleared only by reset.
- `frame_err` out 1: sticky; cleared only by reset.

## Operation
- A transfer occurs on any cycle where `s_valid` && `s_ready` are both high.
- `s_sof` is stored with each pixel as a 13th FIFO bit.
- State machine states, with `s_ready` per state:
  - HUNT: `s_ready`=1, but transfers are discarded unless `s_sof`=1. A transfer with `s_sof`=1 is written to the FIFO and moves the block to FILL.
  - FILL: `s_ready`=!full; transfers are written. Move to ARMED when `level` ≥ `START_LEVEL`.
  - ARMED: writes continue. On `frame_start`, move to STREAM and clear the frame pixel counter.
  - STREAM: writes continue. Each `drawing_pixels` cycle pops one pixel and increments the 20-bit frame counter. Each `frame_start` checks the counter against `FRAME_PIXELS`; on mismatch it sets `frame_err`. The counter then clears.
  - FLUSH: `s_ready`=0 and the FIFO is emptied. On `frame_start`, move to HUNT.
- Underflow: `drawing_pixels`=1 in STREAM with the FIFO empty.
  - Output black and set `underflow`.
  - Move to FLUSH.
- Sticky flags `underflow` and `frame_err` are never cleared except by reset.
- Pop with `s_sof`=1 in STREAM when the frame counter ≠ 0 (misaligned stream):
  - Output the pixel and set `frame_err`.
  - Move to FLUSH.
- `drawing_pixels` outside STREAM pops nothing and outputs black.
- Push and pop in the same cycle leave `level` unchanged.
- A write is impossible when full, because `s_ready`=0 whenever full.
- Pointers wrap modulo `DEPTH`. `level` counts 0..`DEPTH` inclusive.

## Timing
- Reset (asserted low, async) sets:
  - state=HUNT;
  - `r`/`g`/`b`=0 and `s_ready`=0 while reset is low;
  - `level`=0, `underflow`=0, `frame_err`=0, pointers=0, frame counter=0.
- `s_ready` may rise the first cycle after reset deasserts.
- Pixel latency: `drawing_pixels` high in cycle N → `r`/`g`/`b` valid in cycle N+1.
- `drawing_pixels` low in cycle N → outputs 0 in N+1.
- `level` is registered and reflects pushes and pops of the previous cycle.
- A push in cycle N is poppable in cycle N+1 (no fall-through in the same cycle).
- `s_ready` is combinational from state and full; there is no combinational path from `s_valid` to `s_ready`.
- `frame_start` in the same cycle as the FILL→ARMED transition is ignored; ARMED waits for the next pulse.
- Reset mid-frame aborts immediately; there is no drain.

## Structure
- Package `vistreamer_pkg` holds:
  - RGB444 field widths and slice positions;
  - the state enum (HUNT, FILL, ARMED, STREAM, FLUSH);
  - 800×600 timing constants, shared with the VGA core.
- Sub-module `sync_fifo` (parameterised width 13 and depth; registered read; full/empty/level outputs).
- The top of this block holds the FSM, frame counter, sticky flags and output register.

## Test plan
- Reset with `s_valid`=1: `s_ready`=0 and RGB=0 during reset. After release, non-SOF pixels are discarded (`level` stays 0) until a pixel with `s_sof`=1, then `level`=1.
- Steady state, 600 SOF-aligned lines of 800 pixels at `START_LEVEL`=512:
  - after `frame_start`, pixel 0x0F3 popped at cycle N appears as r=0, g=F, b=3 at N+1;
  - `frame_err`=0 at the next `frame_start`.
- Fill to `DEPTH`=1024 with no pops: `s_ready`=0, `level`=1024, and further `s_valid` is not accepted.
- Starve the FIFO mid-line:
  - RGB=0 starting the cycle after the first empty pop, and `underflow`=1;
  - state FLUSH drains to `level`=0;
  - HUNT at the next `frame_start`, and streaming resumes one frame later.
- Inject `s_sof` at pixel 1000 of a frame: `frame_err`=1 and a FLUSH occurs. Separately, a frame of 479999 pixels sets `frame_err` at `frame_start`.
- Simultaneous push and pop at `level`=5 holds 5. Pointer wrap past index 1023 preserves data order.

Source files
------------

// File: rtl/vistreamer_pkg.sv
// Shared types and constants for the pixel feeder and the 800x600 VGA core.
package vistreamer_pkg;
  localparam int PIX_W   = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 8;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 0;
  localparam int SOF_BIT = PIX_W;
  localparam int FIFO_W  = PIX_W + 1;

  // 800x600 @ 56 Hz, 36 MHz pixel clock
  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 72;
  localparam int H_BP     = 128;
  localparam int H_TOTAL  = 1024;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 22;
  localparam int V_TOTAL  = 625;

  localparam int FRAME_CNT_W = 20;

  typedef enum logic [2:0] {HUNT, FILL, ARMED, STREAM, FLUSH} feed_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port and occupancy count 0..DEPTH.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/pixel_stream_feeder.sv
// Buffers an RGB444 stream and releases it frame-aligned to the VGA core,
// resynchronising at the next frame after underflow or misalignment.
module pixel_stream_feeder
  import vistreamer_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int START_LEVEL  = 512,
  parameter int FRAME_PIXELS = 480000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PIX_W-1:0]         s_data,
  input  logic                     s_sof,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     frame_start,
  input  logic                     drawing_pixels,
  output logic [CH_W-1:0]          r,
  output logic [CH_W-1:0]          g,
  output logic [CH_W-1:0]          b,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic                     frame_err
);
  localparam int AW = $clog2(DEPTH);

  feed_state_e              state, state_nxt;
  logic                     out_en;
  logic                     full, empty, wr_en, rd_en;
  logic [FIFO_W-1:0]        rd_data;
  logic [FRAME_CNT_W-1:0]   frame_cnt;
  logic                     pop_q, pop_nz_q;
  logic                     stream_pop, underrun, misalign, cnt_clr;

  sync_fifo #(.WIDTH(FIFO_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_en),
    .wr_data ({s_sof, s_data}),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign stream_pop = rd_en && (state == STREAM);
  assign underrun   = (state == STREAM) && drawing_pixels && empty;
  // SOF seen one cycle after its pop, judged against the count at pop time
  assign misalign   = pop_q && rd_data[SOF_BIT] && pop_nz_q;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      HUNT: begin
        s_ready = out_en;
        wr_en   = s_valid && out_en && s_sof;
        if (wr_en) state_nxt = FILL;
      end
      FILL: begin
        s_ready = !full;
        wr_en   = s_valid && !full;
        if (level >= (AW+1)'(START_LEVEL)) state_nxt = ARMED;
      end
      ARMED: begin
        s_ready = !full;
        wr_en   = s_valid && !full;
        if (frame_start) begin
          state_nxt = STREAM;
          cnt_clr   = 1'b1;
        end
      end
      STREAM: begin
        s_ready = !full;
        wr_en   = s_valid && !full;
        rd_en   = drawing_pixels && !empty;
        if (underrun || misalign) state_nxt = FLUSH;
      end
      FLUSH: begin
        rd_en = !empty;
        if (frame_start) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      out_en    <= 1'b0;
      pop_q     <= 1'b0;
      pop_nz_q  <= 1'b0;
      frame_cnt <= '0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_en   <= 1'b1;
      pop_q    <= stream_pop;
      pop_nz_q <= (frame_cnt != '0);
      if (cnt_clr || (state == STREAM && frame_start)) frame_cnt <= '0;
      else if (stream_pop)                            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (state == STREAM && frame_start && frame_cnt != FRAME_CNT_W'(FRAME_PIXELS))
        frame_err <= 1'b1;
      if (misalign) frame_err <= 1'b1;
      if (underrun) underflow <= 1'b1;
    end
  end

  // Blanking and non-stream cycles show black
  assign r = pop_q ? rd_data[R_LSB +: CH_W] : '0;
  assign g = pop_q ? rd_data[G_LSB +: CH_W] : '0;
  assign b = pop_q ? rd_data[B_LSB +: CH_W] : '0;
endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Directed bench for pixel_stream_feeder with a queue-based FIFO/output scoreboard.
module tb_pixel_stream_feeder;
  localparam int DEPTH = 64;
  localparam int START = 32;
  localparam int FP    = 200;
  localparam int PRE   = 40;

  logic        clk, reset;
  logic [11:0] s_data;
  logic        s_sof, s_valid, s_ready;
  logic        frame_start, drawing_pixels;
  logic [3:0]  r, g, b;
  logic [6:0]  level;
  logic        underflow, frame_err;

  pixel_stream_feeder #(.DEPTH(DEPTH), .START_LEVEL(START), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .frame_start(frame_start), .drawing_pixels(drawing_pixels),
    .r(r), .g(g), .b(b), .level(level), .underflow(underflow), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          src_k = 0;
  int          inj_k = -1;
  bit          strm = 1'b0;
  logic [12:0] mq [$];
  logic [11:0] exp_q [$];

  function automatic logic [11:0] pix(int k);
    return 12'h0F3 + 12'((k - FP) * 37);
  endfunction

  function automatic logic is_sof(int k);
    return (k % FP == 0) || (k == inj_k);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // pm: 0 idle, 1 offered+accepted, 2 offered+discarded, 3 offered+not ready
  task automatic tick(input int pm, input bit draw, input bit fs);
    logic [12:0] e;
    logic [11:0] d;
    logic        sf;
    d  = pix(src_k);
    sf = is_sof(src_k);
    s_valid = (pm != 0); s_data = d; s_sof = sf;
    drawing_pixels = draw; frame_start = fs;
    if (draw && strm && mq.size() != 0) begin
      e = mq.pop_front();
      exp_q.push_back(e[11:0]);
    end else exp_q.push_back(12'h000);
    if (pm == 1) mq.push_back({sf, d});
    if (pm == 1 || pm == 2) src_k++;
    @(posedge clk); #1;
    chk("rgb", {r, g, b}, exp_q.pop_front());
    s_valid = 1'b0; drawing_pixels = 1'b0; frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("areset_level", level, 0);
    chk("areset_uf", underflow, 0);
    chk("areset_ferr", frame_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    strm = 1'b0;
    mq.delete(); exp_q.delete();
    tick(0, 0, 0);
  endtask

  task automatic start_stream();
    tick(1, 0, 0);
    repeat (PRE) tick(1, 0, 0);
    chk("fill_level", level, PRE + 1);
    tick(0, 0, 1);
    strm = 1'b1;
  endtask

  task automatic end_frame(input logic exp_err);
    tick(0, 0, 0);
    tick(0, 0, 1);
    chk("frame_err", frame_err, exp_err);
    tick(0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b1; s_sof = 1'b0; s_data = 12'h0;
    frame_start = 1'b0; drawing_pixels = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_level", level, 0);
    reset = 1'b1; s_valid = 1'b0; drawing_pixels = 1'b0;
    tick(0, 0, 0);
    chk("hunt_ready", s_ready, 1);

    // Non-SOF pixels are dropped until the frame boundary
    src_k = FP - 3;
    repeat (3) tick(2, 0, 0);
    chk("hunt_drop_level", level, 0);
    tick(1, 0, 0);
    chk("hunt_sof_level", level, 1);
    repeat (PRE) tick(1, 0, 0);
    chk("fill_level", level, PRE + 1);
    tick(0, 0, 1);
    strm = 1'b1;

    // Frame 0: first pixel 0x0F3 one cycle after its pop
    tick(1, 1, 0);
    chk("first_r", r, 4'h0);
    chk("first_g", g, 4'hF);
    chk("first_b", b, 4'h3);
    repeat (FP - 1) tick(1, 1, 0);
    end_frame(1'b0);
    repeat (FP) tick(1, 1, 0);
    end_frame(1'b0);
    chk("steady_level", level, PRE + 1);

    // Frame 2: drain to 5, then push+pop holds level
    repeat (PRE + 1 - 5) tick(0, 1, 0);
    chk("level5", level, 5);
    tick(1, 1, 0);
    chk("push_pop_level", level, 5);
    repeat (FP - (PRE + 1 - 5) - 1) tick(1, 1, 0);
    end_frame(1'b0);

    // Frame 3: starve mid-line
    repeat (5) tick(0, 1, 0);
    tick(0, 1, 0);
    chk("underflow", underflow, 1);
    strm = 1'b0;
    repeat (3) tick(0, 1, 0);
    chk("flush_ready", s_ready, 0);
    chk("flush_level", level, 0);
    tick(0, 0, 1);
    chk("hunt_ready2", s_ready, 1);
    chk("uf_sticky", underflow, 1);
    chk("ferr_clean", frame_err, 0);
    while (src_k % FP != 0) tick(2, 0, 0);
    start_stream();
    repeat (FP) tick(1, 1, 0);
    end_frame(1'b0);

    // Frame 5: stray SOF at pixel 100
    inj_k = src_k - (PRE + 1) + 100;
    repeat (100) tick(1, 1, 0);
    tick(0, 1, 0);
    strm = 1'b0;
    tick(0, 0, 0);
    chk("misalign_ferr", frame_err, 1);
    mq.delete();
    repeat (PRE + 5) tick(0, 0, 0);
    chk("misalign_flush_level", level, 0);
    chk("misalign_flush_ready", s_ready, 0);
    inj_k = -1;

    // Short frame
    do_reset();
    src_k = FP * 10;
    start_stream();
    repeat (FP - 1) tick(1, 1, 0);
    end_frame(1'b1);

    // Fill to full with no pops
    do_reset();
    src_k = FP * 20;
    repeat (DEPTH) tick(1, 0, 0);
    chk("full_level", level, DEPTH);
    chk("full_ready", s_ready, 0);
    repeat (3) tick(3, 0, 0);
    chk("full_hold_level", level, DEPTH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
